mem_gen_pipe: RTL and testbench

//  Parametrised single-clock 1R1W memory with byte-lane write enables, configurable

---
 rtl/mem_gen_pkg.sv | 20 ++
 rtl/mem_gen_clr_seq.sv | 47 ++++
 rtl/mem_gen_pipe.sv | 157 +++++++++++++++
 tb/tb_mem_gen_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_gen_pkg.sv
// Shared types and helpers for the mem_gen_pipe memory block.
// Build option: MEM_GEN_PARITY_EN adds per-lane even parity storage and checking.
package mem_gen_pkg;

  typedef enum logic {
    CLR,
    READY
  } clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest byte lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int LANE_MAX_W = 64;

  function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/mem_gen_clr_seq.sv
// Clear sequencer: zeroes every location after reset or on request by sweeping
// a pointer across the whole array, one location per cycle.
module mem_gen_clr_seq
  import mem_gen_pkg::*;
#(
  parameter int ADDRW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             init_busy,
  output logic             clr_we,
  output logic [ADDRW-1:0] clr_addr
);

  clr_state_e       state;
  logic [ADDRW-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLR;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        default: begin
          if (clr_req) begin
            state     <= CLR;
            ptr       <= '0;
            init_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  assign clr_we   = init_busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/mem_gen_pipe.sv
// Single-clock 1R1W memory with byte-lane writes, write-first bypass, 1 or 2 cycle
// registered read and a hardware clear sweep. Build option: MEM_GEN_PARITY_EN.
module mem_gen_pipe
  import mem_gen_pkg::*;
#(
  parameter int ADDRW  = 10,
  parameter int DATAW  = 32,
  parameter int BYTEW  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  output logic                   init_busy,
  input  logic                   wr_en,
  input  logic [ADDRW-1:0]       wr_addr,
  input  logic [DATAW/BYTEW-1:0] wr_be,
  input  logic [DATAW-1:0]       wr_data,
  input  logic                   rd_en,
  input  logic [ADDRW-1:0]       rd_addr,
  output logic                   rd_valid,
  output logic [DATAW-1:0]       rd_data,
  output logic                   rd_perr
);

  localparam int NBE   = DATAW / BYTEW;
  localparam int DEPTH = 2 ** ADDRW;
`ifdef MEM_GEN_PARITY_EN
  localparam int MW = DATAW + NBE;
`else
  localparam int MW = DATAW;
`endif

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_gen_pipe: RD_LAT must be 1 or 2");
  end
  if (DATAW % BYTEW != 0) begin : g_bad_lanes
    $error("mem_gen_pipe: DATAW must be a multiple of BYTEW");
  end

  logic [MW-1:0] mem [DEPTH];

  logic             clr_we;
  logic [ADDRW-1:0] clr_addr;

  mem_gen_clr_seq #(
    .ADDRW(ADDRW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clear request in READY takes priority over any same-cycle user access.
  logic wr_ok;
  logic rd_ok;
  assign wr_ok = wr_en & ~init_busy & ~clr_req;
  assign rd_ok = rd_en & ~init_busy & ~clr_req;

  logic [MW-1:0] wr_word;
  logic [MW-1:0] wr_mask;

  for (genvar gi = 0; gi < NBE; gi++) begin : g_wr_lane
    assign wr_word[gi*BYTEW +: BYTEW] = wr_data[gi*BYTEW +: BYTEW];
    assign wr_mask[gi*BYTEW +: BYTEW] = {BYTEW{wr_be[gi]}};
`ifdef MEM_GEN_PARITY_EN
    assign wr_word[DATAW+gi] = lane_parity(LANE_MAX_W'(wr_data[gi*BYTEW +: BYTEW]));
    assign wr_mask[DATAW+gi] = wr_be[gi];
`endif
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NBE; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTEW +: BYTEW] <= wr_word[i*BYTEW +: BYTEW];
`ifdef MEM_GEN_PARITY_EN
          mem[wr_addr][DATAW+i] <= wr_word[DATAW+i];
`endif
        end
      end
    end
  end

  // Write-first: lanes being written this cycle are forwarded into the read.
  logic [MW-1:0] rd_raw;
  logic [MW-1:0] rd_merged;
  logic          rd_err;

  assign rd_raw    = mem[rd_addr];
  assign rd_merged = (wr_ok && (wr_addr == rd_addr))
                   ? ((rd_raw & ~wr_mask) | (wr_word & wr_mask))
                   : rd_raw;

`ifdef MEM_GEN_PARITY_EN
  logic [NBE-1:0] lane_err;
  for (genvar gi = 0; gi < NBE; gi++) begin : g_par_chk
    assign lane_err[gi] = lane_parity(LANE_MAX_W'(rd_merged[gi*BYTEW +: BYTEW]))
                        ^ rd_merged[DATAW+gi];
  end
  assign rd_err = |lane_err;
`else
  assign rd_err = 1'b0;
`endif

  logic             s1_valid;
  logic             s1_perr;
  logic [DATAW-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_perr  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      s1_perr  <= rd_ok & rd_err;
      if (rd_ok) begin
        s1_data <= rd_merged[DATAW-1:0];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             s2_valid;
    logic             s2_perr;
    logic [DATAW-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_perr  <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_perr  <= s1_perr;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rd_valid = s2_valid;
    assign rd_perr  = s2_perr;
    assign rd_data  = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_perr  = s1_perr;
    assign rd_data  = s1_data;
  end

endmodule

// File: tb/tb_mem_gen_pipe.sv
// Directed bench for mem_gen_pipe with a read scoreboard; covers the parity path
// when built with MEM_GEN_PARITY_EN.
module tb_mem_gen_pipe;

  parameter int RD_LAT = 1;
  localparam int ADDRW = 10;
  localparam int DATAW = 32;
  localparam int DEPTH = 2 ** ADDRW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_req;
  logic             init_busy;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [3:0]       wr_be;
  logic [DATAW-1:0] wr_data;
  logic             rd_en;
  logic [ADDRW-1:0] rd_addr;
  logic             rd_valid;
  logic [DATAW-1:0] rd_data;
  logic             rd_perr;

  mem_gen_pipe #(
    .ADDRW (ADDRW),
    .DATAW (DATAW),
    .BYTEW (8),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .init_busy(init_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_perr  (rd_perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATAW-1:0] data;
    int               due;
    logic             perr;
  } rd_item_t;

  rd_item_t         sb[$];
  logic [DATAW-1:0] model [DEPTH];
  logic [DATAW-1:0] last_exp = '0;
  int               checks = 0;
  int               failures = 0;
  int               n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clr_req = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  // Advance one clock, then score whatever the read port shows.
  task automatic tick();
    rd_item_t it;
    @(posedge clk);
    #1;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rd_valid", {63'd0, rd_valid}, 64'd0);
      end else begin
        it = sb.pop_front();
        chk("rd_data", {32'd0, rd_data}, {32'd0, it.data});
        chk("rd_latency", 64'(cyc), 64'(it.due));
        chk("rd_perr", {63'd0, rd_perr}, {63'd0, it.perr});
        last_exp = it.data;
        $display("read  t=%0d data=%08h perr=%0b", cyc, rd_data, rd_perr);
      end
    end else begin
      chk("rd_data_hold", {32'd0, rd_data}, {32'd0, last_exp});
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("missing_rd_valid", {63'd0, rd_valid}, 64'd1);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic cycle();
    tick();
    idle();
  endtask

  task automatic do_wr(input logic [ADDRW-1:0] a, input logic [3:0] be, input logic [DATAW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
    end
    $display("write t=%0d addr=%03h be=%04b data=%08h", cyc, a, be, d);
  endtask

  task automatic do_rd(input logic [ADDRW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    sb.push_back('{data: model[a], due: cyc + RD_LAT, perr: 1'b0});
  endtask

  task automatic drain();
    repeat (RD_LAT + 2) cycle();
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    idle();
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_init_busy", {63'd0, init_busy}, 64'd1);
    chk("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
    chk("reset_rd_perr", {63'd0, rd_perr}, 64'd0);

    // Power-up sweep length.
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 2000);
    chk("init_sweep_cycles", 64'(n), 64'(DEPTH));

    do_rd(10'h3FF);
    cycle();
    drain();

    // Partial-lane write then read back.
    do_wr(10'h3AA, 4'b0101, 32'hDEADBEEF);
    cycle();
    do_rd(10'h3AA);
    cycle();
    drain();

    // Same-cycle write/read bypass with lane merge, then stored value.
    do_wr(10'h010, 4'b1111, 32'hAABBCCDD);
    cycle();
    do_wr(10'h010, 4'b1100, 32'h12345678);
    do_rd(10'h010);
    cycle();
    do_rd(10'h010);
    cycle();
    do_wr(10'h3AA, 4'b0000, 32'hFFFFFFFF);
    do_rd(10'h3AA);
    cycle();
    drain();

    // Fill a block and read it back fully pipelined.
    for (int i = 0; i < 16; i++) begin
      do_wr(ADDRW'(i), 4'b1111, (32'h01010101 * (i + 1)) ^ 32'hC3A50000);
      cycle();
    end
    for (int i = 0; i < 16; i++) begin
      do_rd(ADDRW'(i));
      cycle();
    end
    drain();

    // In-flight read survives a clear; same-cycle accesses with clear are dropped.
    do_rd(10'h005);
    cycle();
    clr_req = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 10'h006;
    wr_en   = 1'b1;
    wr_addr = 10'h007;
    wr_be   = 4'b1111;
    wr_data = 32'h77777777;
    cycle();
    model_clear();
    chk("clr_init_busy", {63'd0, init_busy}, 64'd1);
    n = 0;
    do begin
      wr_en   = 1'b1;
      wr_addr = 10'h000;
      wr_be   = 4'b1111;
      wr_data = 32'hFFFFFFFF;
      rd_en   = 1'b1;
      rd_addr = 10'h000;
      tick();
      n++;
    end while (init_busy && n < 2000);
    idle();
    chk("clr_sweep_cycles", 64'(n), 64'(DEPTH));
    for (int i = 0; i < 16; i++) begin
      do_rd(ADDRW'(i));
      cycle();
    end
    do_rd(10'h010);
    cycle();
    do_rd(10'h3AA);
    cycle();
    drain();

    // Reset in the middle of a sweep restarts it from the beginning.
    do_wr(10'h3F0, 4'b1111, 32'h5555AAAA);
    cycle();
    clr_req = 1'b1;
    cycle();
    model_clear();
    repeat (500) cycle();
    chk("mid_sweep_busy", {63'd0, init_busy}, 64'd1);
    rst_n    = 1'b0;
    last_exp = '0;
    #2;
    chk("mid_reset_busy", {63'd0, init_busy}, 64'd1);
    chk("mid_reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 2000);
    chk("restart_sweep_cycles", 64'(n), 64'(DEPTH));
    do_rd(10'h3F0);
    cycle();
    do_rd(10'h000);
    cycle();
    drain();

`ifdef MEM_GEN_PARITY_EN
    do_wr(10'h020, 4'b1111, 32'h0F0F1234);
    cycle();
    do_wr(10'h021, 4'b1111, 32'h5A5A5A5B);
    cycle();
    dut.mem[10'h020][3] = ~dut.mem[10'h020][3];
    rd_en   = 1'b1;
    rd_addr = 10'h020;
    sb.push_back('{data: model[10'h020] ^ 32'h00000008, due: cyc + RD_LAT, perr: 1'b1});
    cycle();
    do_rd(10'h021);
    cycle();
    drain();
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
